// File: rtl/packet_arbiter.sv
// packet_arbiter: round-robin arbiter merging PORTS valid/ready/last packet
// streams into one registered output stream, one whole packet per grant.
//   clock, reset_n       : rising-edge clock, synchronous active-low reset
//   valid_i/last_i/data_i: per-port upstream beats (port p at data_i[p*WIDTH +: WIDTH])
//   ready_o              : per-port accept, only the granted port can be high
//   valid_o/last_o/data_o: registered downstream beat, accepted by ready_i
//   grant_o              : current or most recent granted port
//   busy_o               : a packet is in progress
module packet_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PORTS = 4,
  parameter int unsigned GBITS = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [PORTS-1:0]       valid_i,
  output logic [PORTS-1:0]       ready_o,
  input  logic [PORTS-1:0]       last_i,
  input  logic [PORTS*WIDTH-1:0] data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   last_o,
  output logic [WIDTH-1:0]       data_o,
  output logic [GBITS-1:0]       grant_o,
  output logic                   busy_o
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_BUSY  = 1'b1;
  localparam logic [GBITS-1:0] LAST_RST = GBITS'(PORTS - 1);

  logic [0:0]       state_q,  state_d;
  logic [GBITS-1:0] grant_q,  grant_d;
  logic [GBITS-1:0] last_g_q, last_g_d;
  logic             valid_q,  valid_d;
  logic             last_q,   last_d;
  logic [WIDTH-1:0] data_q,   data_d;

  logic [GBITS-1:0] pick_c;
  logic             pick_vld_c;
  logic             beat_valid_c;
  logic             beat_last_c;
  logic [WIDTH-1:0] beat_data_c;
  logic             free_c;
  logic             accept_c;

  // Round-robin search: first requesting port after the previous winner.
  always_comb begin
    logic [GBITS-1:0] cand;
    cand       = '0;
    pick_c     = '0;
    pick_vld_c = 1'b0;
    for (int unsigned i = 1; i <= PORTS; i++) begin
      cand = GBITS'((32'(last_g_q) + i) % PORTS);
      if (!pick_vld_c && valid_i[cand]) begin
        pick_c     = cand;
        pick_vld_c = 1'b1;
      end
    end
  end

  // Only the granted port's inputs are looked at, so others may carry X.
  always_comb begin
    beat_valid_c = valid_i[grant_q];
    beat_last_c  = last_i[grant_q];
    beat_data_c  = data_i[32'(grant_q) * WIDTH +: WIDTH];
  end

  // Output register can take a beat when empty or draining this cycle.
  assign free_c   = !valid_q || ready_i;
  assign accept_c = (state_q == ST_BUSY) && beat_valid_c && free_c;

  // ready depends on state, output register and ready_i only, never valid_i.
  always_comb begin
    ready_o = '0;
    if (state_q == ST_BUSY) begin
      ready_o[grant_q] = free_c;
    end
  end

  // Next-state and output-register update.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_g_d = last_g_q;
    valid_d  = valid_q;
    last_d   = last_q;
    data_d   = data_q;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    // A new load overrides the drain so back-to-back beats leave no bubble.
    if (accept_c) begin
      valid_d = 1'b1;
      data_d  = beat_data_c;
      last_d  = beat_last_c;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_vld_c) begin
          grant_d = pick_c;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept_c && beat_last_c) begin
          last_g_d = grant_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      last_g_q <= LAST_RST;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_g_q <= last_g_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      data_q   <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign data_o  = data_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q == ST_BUSY);

endmodule

// File: tb/tb_packet_arbiter.sv
// tb_packet_arbiter: directed timing checks plus scoreboard phases where a
// packet-level round-robin model predicts upstream accept order and the
// downstream beat sequence; a negedge monitor pops and compares.
module tb_packet_arbiter;

  localparam int WIDTH = 8;
  localparam int PORTS = 4;
  localparam int GBITS = 2;
  localparam int MAXB  = 64;
  localparam int MAXP  = 16;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic [PORTS-1:0]       valid_i;
  logic [PORTS-1:0]       ready_o;
  logic [PORTS-1:0]       last_i;
  logic [PORTS*WIDTH-1:0] data_i;
  logic                   valid_o;
  logic                   ready_i;
  logic                   last_o;
  logic [WIDTH-1:0]       data_o;
  logic [GBITS-1:0]       grant_o;
  logic                   busy_o;

  packet_arbiter #(.WIDTH(WIDTH), .PORTS(PORTS), .GBITS(GBITS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .last_i  (last_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .last_o  (last_o),
    .data_o  (data_o),
    .grant_o (grant_o),
    .busy_o  (busy_o)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  // Per-port source beat lists and progress.
  logic [WIDTH-1:0] src_data [PORTS][MAXB];
  logic             src_last [PORTS][MAXB];
  int               src_len  [PORTS];
  int               src_pos  [PORTS];

  beat_t exp_out[$];
  int    exp_acc[$];

  bit sb_en      = 1'b0;
  bit gap_en     = 1'b0;
  bit gap_chk    = 1'b0;
  int ready_mode = 0;

  // Builds packets and predicts the order they are served in.
  task automatic build(input logic [PORTS-1:0] mask, input int npk, input int lmin, input int lmax);
    int    pk_start [PORTS][MAXP];
    int    pk_len   [PORTS][MAXP];
    int    pk_cnt   [PORTS];
    int    nxt      [PORTS];
    int    lg;
    int    g;
    beat_t b;
    for (int p = 0; p < PORTS; p++) begin
      src_len[p] = 0;
      src_pos[p] = 0;
      pk_cnt[p]  = 0;
      nxt[p]     = 0;
      if (mask[p]) begin
        for (int k = 0; k < npk; k++) begin
          int len;
          len = int'($urandom_range(lmax, lmin));
          pk_start[p][k] = src_len[p];
          pk_len[p][k]   = len;
          pk_cnt[p]++;
          for (int j = 0; j < len; j++) begin
            src_data[p][src_len[p]] = WIDTH'($urandom);
            src_last[p][src_len[p]] = (j == len - 1);
            src_len[p]++;
          end
        end
      end
    end
    // After reset the previous winner is the highest port, so port 0 comes first.
    lg = PORTS - 1;
    forever begin
      g = -1;
      for (int i = 1; i <= PORTS; i++) begin
        int c;
        c = (lg + i) % PORTS;
        if (g < 0 && nxt[c] < pk_cnt[c]) g = c;
      end
      if (g < 0) break;
      for (int j = 0; j < pk_len[g][nxt[g]]; j++) begin
        int ix;
        ix = pk_start[g][nxt[g]] + j;
        b.data = src_data[g][ix];
        b.last = src_last[g][ix];
        exp_out.push_back(b);
        exp_acc.push_back(g);
      end
      nxt[g]++;
      lg = g;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    valid_i = '0;
    last_i  = '0;
    data_i  = '0;
    ready_i = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // One cycle of the upstream sources and the downstream sink.
  task automatic drive_step();
    logic [PORTS-1:0] acc;
    @(negedge clock);
    acc = valid_i & ready_o;
    tick();
    for (int p = 0; p < PORTS; p++) begin
      bit has;
      bit mid;
      if (acc[p]) src_pos[p]++;
      has = src_pos[p] < src_len[p];
      mid = 1'b0;
      if (has && src_pos[p] > 0) mid = !src_last[p][src_pos[p] - 1];
      // Sources pause only inside a packet, never at a packet start.
      valid_i[p] = has && !(gap_en && mid && ($urandom_range(0, 2) == 0));
      data_i[p*WIDTH +: WIDTH] = has ? src_data[p][src_pos[p]] : WIDTH'($urandom);
      last_i[p] = has ? src_last[p][src_pos[p]] : 1'b0;
    end
    case (ready_mode)
      0:       ready_i = 1'b1;
      1:       ready_i = ~ready_i;
      default: ready_i = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic run_phase(input string name, input logic [PORTS-1:0] mask, input int npk,
                           input int lmin, input int lmax, input bit gaps, input int rmode,
                           input bit gchk);
    int n;
    do_reset();
    exp_out.delete();
    exp_acc.delete();
    build(mask, npk, lmin, lmax);
    gap_en     = gaps;
    ready_mode = rmode;
    gap_chk    = gchk;
    sb_en      = 1'b1;
    n = 0;
    while ((exp_out.size() != 0 || exp_acc.size() != 0) && n < 3000) begin
      drive_step();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_timeout: outstanding=%0d required=0", name, exp_out.size());
    end
    // Keep watching so any extra or duplicated beat is caught.
    repeat (8) drive_step();
    sb_en = 1'b0;
  endtask

  // Monitor state.
  bit               prev_stall;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;
  int               gap_cnt;
  bit               after_last;
  bit               first_xfer;

  always @(negedge clock) begin
    if (sb_en) begin
      logic [PORTS-1:0] er;
      beat_t            e;
      int               ep;
      for (int p = 0; p < PORTS; p++) begin
        if (valid_i[p] && ready_o[p]) begin
          if (exp_acc.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept: port=%0d required none", p);
          end else begin
            ep = exp_acc.pop_front();
            check("accept_port", p, ep);
            check("grant_at_accept", 32'(grant_o), ep);
          end
        end
      end

      er = '0;
      if (busy_o) er[grant_o] = !valid_o || ready_i;
      check("ready_rule", 32'(ready_o), 32'(er));

      if (prev_stall) begin
        check("hold_valid", 32'(valid_o), 1);
        check("hold_data", 32'(data_o), 32'(prev_data));
        check("hold_last", 32'(last_o), 32'(prev_last));
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      prev_last  = last_o;

      if (valid_o && ready_i) begin
        if (exp_out.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: data=0x%0h required none", data_o);
        end else begin
          e = exp_out.pop_front();
          check("out_data", 32'(data_o), 32'(e.data));
          check("out_last", 32'(last_o), 32'(e.last));
        end
        if (gap_chk && !first_xfer && after_last) check("idle_gap", gap_cnt, 1);
        after_last = last_o;
        first_xfer = 1'b0;
        gap_cnt    = 0;
      end else if (!valid_o) begin
        gap_cnt++;
      end
    end else begin
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      gap_cnt    = 0;
      after_last = 1'b0;
      first_xfer = 1'b1;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_valid_o"}, 32'(valid_o), 0);
    check({tag, "_last_o"},  32'(last_o),  0);
    check({tag, "_data_o"},  32'(data_o),  0);
    check({tag, "_grant_o"}, 32'(grant_o), 0);
    check({tag, "_busy_o"},  32'(busy_o),  0);
    check({tag, "_ready_o"}, 32'(ready_o), 0);
  endtask

  initial begin
    // Reset values.
    do_reset();
    check_all_zero("rst");

    // Single port, 3-beat packet, downstream always ready.
    valid_i = 4'b0001;
    data_i[7:0] = 8'hA1;
    last_i = '0;
    tick();
    check("sp_busy_k", 32'(busy_o), 1);
    check("sp_grant_k", 32'(grant_o), 0);
    check("sp_valid_k", 32'(valid_o), 0);
    check("sp_ready_k", 32'(ready_o), 32'h1);
    tick();
    check("sp_valid_k1", 32'(valid_o), 1);
    check("sp_data_a1", 32'(data_o), 32'hA1);
    check("sp_last_a1", 32'(last_o), 0);
    data_i[7:0] = 8'hA2;
    tick();
    check("sp_data_a2", 32'(data_o), 32'hA2);
    check("sp_last_a2", 32'(last_o), 0);
    data_i[7:0] = 8'hA3;
    last_i = 4'b0001;
    tick();
    check("sp_data_a3", 32'(data_o), 32'hA3);
    check("sp_last_a3", 32'(last_o), 1);
    check("sp_busy_after", 32'(busy_o), 0);
    valid_i = '0;
    last_i  = '0;
    tick();
    check("sp_valid_drained", 32'(valid_o), 0);
    check("sp_grant_hold", 32'(grant_o), 0);

    // Mid-packet stall on port 2, then reset.
    do_reset();
    valid_i = 4'b0100;
    data_i[23:16] = 8'h31;
    tick();
    check("st_grant", 32'(grant_o), 2);
    check("st_busy", 32'(busy_o), 1);
    tick();
    valid_i = 4'b1001;
    data_i[7:0]   = 8'h55;
    data_i[31:24] = 8'h66;
    repeat (3) begin
      tick();
      check("st_busy_held", 32'(busy_o), 1);
      check("st_grant_held", 32'(grant_o), 2);
      check("st_other_ready", 32'(ready_o & 4'b1011), 0);
    end
    check("st_no_other_served", 32'(valid_o), 0);
    reset_n = 1'b0;
    tick();
    check_all_zero("mid_rst");
    reset_n = 1'b1;
    tick();
    check("rst_both_grant", 32'(grant_o), 0);
    reset_n = 1'b0;
    valid_i = 4'b1000;
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_p3_grant", 32'(grant_o), 3);
    valid_i = '0;

    // Scoreboard phases.
    run_phase("rr_all",     4'b1111, 2, 2, 2, 1'b0, 0, 1'b1);
    run_phase("backpress",  4'b0010, 1, 4, 4, 1'b0, 1, 1'b0);
    run_phase("wrap_skip",  4'b0110, 2, 1, 3, 1'b0, 0, 1'b1);
    run_phase("single",     4'b0011, 3, 1, 1, 1'b0, 0, 1'b1);
    run_phase("rand_all",   4'b1111, 8, 1, 4, 1'b1, 2, 1'b0);
    run_phase("rand_togl",  4'b1011, 6, 1, 4, 1'b1, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/packet_arbiter.md
# packet_arbiter

Round-robin arbiter that shares one downstream packet stream, typically the write side of a `packet_fifo` or `sync_fifo`, between `PORTS` upstream requesters. Each requester presents a valid/ready/last packet stream. The arbiter grants one port for a whole packet and forwards its beats through a single output register. After the `last` beat it rotates priority. It sits between multiple command/data producers and the shared FIFO ahead of the DDR3 controller.

## Interface
- `WIDTH`, default 8: data width per beat.
- `PORTS`, default 4: number of requesters. Legal range 2..8.
- `GBITS`, default 2: grant index width, equal to clog2(`PORTS`).
- `clock`, in, 1: single clock; all logic is rising-edge.
- `reset_n`, in, 1: synchronous, active-low reset, sampled on the rising edge of `clock`.
- `valid_i`, in, `PORTS`: per-port beat valid.
- `ready_o`, out, `PORTS`: per-port beat accept.
- `last_i`, in, `PORTS`: per-port end-of-packet flag.
- `data_i`, in, `PORTS`*`WIDTH`: port p occupies bits [p*`WIDTH` +: `WIDTH`].
- `valid_o`, out, 1: output beat valid (registered).
- `ready_i`, in, 1: downstream accept.
- `last_o`, out, 1: output end-of-packet (registered).
- `data_o`, out, `WIDTH`: output beat (registered).
- `grant_o`, out, `GBITS`: index of the currently or most recently granted port.
- `busy_o`, out, 1: high while a packet is in progress (state BUSY).

## Operation
- The FSM has two states, IDLE and BUSY. Reset state is IDLE.
- Priority pointer `last_g` has reset value `PORTS`-1, so port 0 wins first.
- **IDLE**
  - If any `valid_i` is high, select the first asserted port searching `last_g`+1, `last_g`+2, … modulo `PORTS`.
  - Register the selection into `grant_o`, then go to BUSY.
  - If no `valid_i` is high, remain in IDLE.
  - All `ready_o` are 0 in IDLE.
- **BUSY**
  - `ready_o[grant_o]` = `!valid_o || ready_i`. All other `ready_o` bits are 0.
  - Beat accept: `valid_i[g] && ready_o[g]`, where g = `grant_o`. On accept, the output register loads `data_i[g]` and `last_i[g]`, and sets `valid_o`=1.
  - On an accepted beat with `last_i[g]`=1: set `last_g` <= g and go to IDLE on the same edge.
- **Output register**
  - If `valid_o && ready_i` and no new beat is loaded, clear `valid_o`.
  - `data_o` and `last_o` hold their values while `valid_o && !ready_i`.
- A granted port may deassert `valid_i` mid-packet. The arbiter stays in BUSY and keeps the grant; there is no timeout and no preemption.
- Input values on non-granted ports are ignored, including X.
- Modulo wrap: when searching from `last_g`=`PORTS`-1, the search starts at port 0.
- Simultaneous events:
  - Downstream drain and new load in the same cycle: the register is overwritten, `valid_o` stays 1, and there is no bubble.
  - A single-beat packet is accepted in the first BUSY cycle with `last_i`=1. The FSM returns to IDLE and the next arbitration happens in the following cycle.
- Reset mid-packet (`reset_n`=0 at any edge):
  - FSM goes to IDLE, `valid_o`=0, `last_o`=0, `data_o`=0, `grant_o`=0, `busy_o`=0, `last_g`=`PORTS`-1, all `ready_o`=0.
  - The partial packet is discarded. Upstream re-sends it.

## Timing
- Reset values: every output is 0.
- Arbitration latency:
  - `valid_i` high in IDLE at edge k: BUSY and `grant_o` are visible after edge k.
  - The first `ready_o` is high in cycle k+1 (if the output register is free).
  - The first beat is loaded at edge k+1, and `valid_o` goes high after k+1.
  - Result: 2 cycles from request to `valid_o`.
- Throughput:
  - One beat per cycle within a packet while `ready_i`=1.
  - Exactly one idle cycle (an IDLE arbitration cycle) between consecutive packets.
- Backpressure: `ready_o[g]` follows `ready_i` combinationally while `valid_o`=1. There is no combinational path from any `valid_i` to any `ready_o`.
- `busy_o` equals (state == BUSY). `grant_o` changes only on the IDLE→BUSY edge.

## Test plan
- **Single port:** after reset, port 0 sends a 3-beat packet (0xA1, 0xA2, 0xA3 with last) while `ready_i`=1.
  - `valid_o` rises 2 cycles after `valid_i[0]`.
  - `data_o` is A1, A2, A3 on consecutive cycles, with `last_o` on A3.
  - `grant_o`=0, `busy_o` is low 1 cycle after A3 is accepted.
- **All ports continuously requesting, 2-beat packets, `PORTS`=4:**
  - Grant order is 0,1,2,3,0.
  - Beats from different ports never interleave.
  - Exactly 1 idle output cycle between packets.
- **Backpressure:** `ready_i` toggles 1/0 every cycle during a 4-beat packet.
  - `data_o` holds while `valid_o && !ready_i`.
  - All 4 beats are delivered in order with no loss or duplication.
  - `ready_o[g]` mirrors `ready_i` while `valid_o`=1.
- **Wrap and skip:** `last_g`=3, only ports 1 and 2 request.
  - Port 1 is granted, then port 2, then port 1.
  - A port that withdraws `valid_i` during IDLE is skipped.
- **Mid-packet stall and reset:** port 2 drops `valid_i` after beat 1 of 3.
  - Grant and BUSY are held, and no other port is served.
  - Asserting `reset_n`=0 for one edge clears all outputs to 0.
  - The next request from port 3 is granted before port 0 only if port 0 is idle; port 0 wins if both request.
- **Single-beat packets back-to-back from ports 0 and 1 with `ready_i`=1:** `valid_o` pattern is 1,0,1,0… Each `last_o`=1, and `grant_o` alternates 0,1.
